proc_sequencer: RTL and testbench
=================================

Name: proc_sequencer

Overview:
Instruction-fetch controller that drives the 9-bit simple processor (mv/mvi/add/sub) from a synchronous 9-bit program ROM. It owns the program counter, presents opcode and immediate words on the processor's DIN, pulses Run and waits for Done. It supports continuous run, single-step, halt and illegal-opcode skipping. It sits between the ROM and the processor in the lab top level.

Parameters:
AW, 5, ROM address width (program of 2^AW words).
TIMEOUT, 7, maximum cycles WAIT may last without Done before Error is set.

Ports:
Clock  in  1  system clock
Resetn  in  1  synchronous, active-low reset
Start  in  1  pulse: clear PC to 0 and enter continuous run
Step  in  1  pulse: execute exactly one instruction from the current PC, then pause
Pause  in  1  level: stop after the current instruction completes
Rom_Addr  out  AW  ROM read address; ROM returns data exactly one clock later
Rom_Q  in  9  ROM read data
Proc_DIN  out  9  drives the processor's DIN
Proc_Run  out  1  drives the processor's Run
Proc_Done  in  1  processor Done (combinational, valid in the same cycle)
PC  out  AW  address of the next or current instruction
Busy  out  1  high in FETCH/ISSUE/WAIT
Halted  out  1  sticky high after a HALT opcode
Illegal  out  1  sticky high after any skipped opcode 100–110
Error  out  1  sticky high on Done timeout
Instr_Count  out  16  count of retired instructions, saturating at 16'hFFFF

Behaviour:
- Reset is synchronous and active-low: Resetn sampled low at a Clock edge.
  - State goes to IDLE.
  - PC, Instr_Count, Halted, Illegal and Error clear to 0.
  - Proc_Run=0, Proc_DIN=0, Rom_Addr=0.
  - Reset mid-instruction abandons it with no retire. The processor shares Resetn, so both return to their idle step together.
- Opcode field is word[8:6]:
  - 000 mv, 001 mvi (two words), 010 add, 011 sub.
  - 111 HALT, which is never issued to the processor.
  - 100–110 illegal.
- States:
  - IDLE:
    - Proc_Run=0, Proc_DIN=0, Rom_Addr=PC.
    - Start → PC:=0, clear Halted, enter FETCH in continuous mode.
    - Step → FETCH in step mode.
    - Start wins over Step when both are asserted.
  - FETCH (1 cycle): Rom_Addr=PC → ISSUE.
  - ISSUE (1 cycle): decode Rom_Q.
    - Legal 000–011: Proc_DIN=Rom_Q, Proc_Run=1, Rom_Addr=PC+1 → WAIT.
    - HALT: set Halted; PC unchanged → IDLE.
    - Illegal: set Illegal; PC:=PC+1; Run not asserted → FETCH (continuous) or IDLE (step).
  - WAIT:
    - Proc_Run=0; Proc_DIN=Rom_Q, which holds the PC+1 word, i.e. the mvi immediate during the processor's T1.
    - On Proc_Done: retire the instruction, Instr_Count+1, PC:=PC+2 for mvi and PC+1 otherwise.
    - Next state after retire: IDLE if in step mode or Pause=1; FETCH otherwise.
    - No Done within TIMEOUT cycles: set Error, PC:=PC+1 → IDLE.
- Latency:
  - mv/mvi: 3 cycles from FETCH to retire.
  - add/sub: 5 cycles.
  - Done must arrive 1 cycle (mv/mvi) or 3 cycles (add/sub) after the ISSUE cycle.
- PC wraps modulo 2^AW. An mvi at the last address takes its immediate from address 0.
- Start or Step while Busy are ignored. Pause while IDLE has no effect.
- Proc_Run is high only in ISSUE, and never on two consecutive cycles.
- All outputs are registered except Proc_DIN, Proc_Run and Rom_Addr, which are decoded from the state register.

Decomposition:
- Shared package proc_pkg holds:
  - Opcode constants OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011, OP_HALT=3'b111.
  - State encoding: IDLE, FETCH, ISSUE, WAIT.
- Sub-module seq_watchdog: a loadable down-counter with a TIMEOUT parameter and an expired output.
- PC, mode flag and statistics stay in the top module.

Test Plan:
- ROM[0]=9'b001000000 (mvi R0), ROM[1]=9'd5, ROM[2]=9'b111000000; Start → Proc_Run high once, Proc_DIN=5 during WAIT, R0=5, PC=2, Halted=1, Instr_Count=1.
- Program mvi R0,#3; mvi R1,#4; add R0,R1 (9'b010000001); HALT; Start → R0=7, Instr_Count=3, add retire exactly 3 cycles after its ISSUE.
- ROM[0]=9'b101000000 then HALT; Start → Illegal=1, Proc_Run never asserted for word 0, PC=1, Halted=1.
- Step pulses on a 3-instruction program → one retire per pulse, returns to IDLE each time, PC advances 2,4,5.
- Stub Proc_Done tied 0; Start → Error=1 after 7 WAIT cycles, state IDLE, PC=1.
- Resetn low during WAIT of an add → next cycle IDLE, PC=0, Instr_Count=0, Proc_Run=0; a later Start restarts cleanly.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared opcode and state definitions for the program sequencer and its watchdog.
package proc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait
    } seq_state_e;

    // Only opcodes 000-011 reach the processor; HALT is handled before this test.
    function automatic logic op_legal(input logic [2:0] op);
        return !op[2];
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Loadable down-counter bounding how long the sequencer waits for Done.
module seq_watchdog #(
    parameter int unsigned TIMEOUT = 7
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Loaded with TIMEOUT-1 so expired is high during the last permitted wait cycle.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(TIMEOUT - 1);
        end else if (dec && count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/proc_sequencer.sv
// Instruction-fetch controller feeding the 9-bit simple processor from a synchronous ROM.
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned AW      = 5,
    parameter int unsigned TIMEOUT = 7
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Start,
    input  logic          Step,
    input  logic          Pause,
    output logic [AW-1:0] Rom_Addr,
    input  logic [8:0]    Rom_Q,
    output logic [8:0]    Proc_DIN,
    output logic          Proc_Run,
    input  logic          Proc_Done,
    output logic [AW-1:0] PC,
    output logic          Busy,
    output logic          Halted,
    output logic          Illegal,
    output logic          Error,
    output logic [15:0]   Instr_Count
);

    seq_state_e state;
    logic       step_mode;
    logic       is_mvi;
    logic       wd_expired;
    logic [2:0] op;

    assign op = Rom_Q[8:6];

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .load    ((state == StIssue) && op_legal(op)),
        .dec     (state == StWait),
        .expired (wd_expired)
    );

    // From ISSUE onward the ROM is pointed at PC+1 so WAIT sees the mvi immediate.
    always_comb begin
        Proc_Run = 1'b0;
        Proc_DIN = '0;
        Rom_Addr = PC;
        case (state)
            StIssue: begin
                Rom_Addr = PC + 1'b1;
                if (op_legal(op)) begin
                    Proc_Run = 1'b1;
                    Proc_DIN = Rom_Q;
                end
            end
            StWait: begin
                Rom_Addr = PC + 1'b1;
                Proc_DIN = Rom_Q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state       <= StIdle;
            PC          <= '0;
            Instr_Count <= '0;
            Busy        <= 1'b0;
            Halted      <= 1'b0;
            Illegal     <= 1'b0;
            Error       <= 1'b0;
            step_mode   <= 1'b0;
            is_mvi      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (Start) begin
                        PC        <= '0;
                        Halted    <= 1'b0;
                        step_mode <= 1'b0;
                        Busy      <= 1'b1;
                        state     <= StFetch;
                    end else if (Step) begin
                        step_mode <= 1'b1;
                        Busy      <= 1'b1;
                        state     <= StFetch;
                    end
                end
                StFetch: state <= StIssue;
                StIssue: begin
                    is_mvi <= (op == OP_MVI);
                    if (op == OP_HALT) begin
                        Halted <= 1'b1;
                        Busy   <= 1'b0;
                        state  <= StIdle;
                    end else if (op_legal(op)) begin
                        state <= StWait;
                    end else begin
                        Illegal <= 1'b1;
                        PC      <= PC + 1'b1;
                        if (step_mode) begin
                            Busy  <= 1'b0;
                            state <= StIdle;
                        end else begin
                            state <= StFetch;
                        end
                    end
                end
                StWait: begin
                    if (Proc_Done) begin
                        if (Instr_Count != 16'hFFFF) Instr_Count <= Instr_Count + 1'b1;
                        PC <= is_mvi ? PC + AW'(2) : PC + AW'(1);
                        if (step_mode || Pause) begin
                            Busy  <= 1'b0;
                            state <= StIdle;
                        end else begin
                            state <= StFetch;
                        end
                    end else if (wd_expired) begin
                        Error <= 1'b1;
                        PC    <= PC + 1'b1;
                        Busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench: ROM + processor models around the sequencer, checked against an ISA-level program model.
module tb_proc_sequencer;

    localparam int AW = 5;
    localparam logic [8:0] HALT_W = 9'b111000000;

    logic          Clock = 1'b0;
    logic          Resetn = 1'b0;
    logic          Start = 1'b0;
    logic          Step = 1'b0;
    logic          Pause = 1'b0;
    logic [AW-1:0] Rom_Addr;
    logic [8:0]    Rom_Q;
    logic [8:0]    Proc_DIN;
    logic          Proc_Run;
    logic          Proc_Done;
    logic [AW-1:0] PC;
    logic          Busy, Halted, Illegal, Error;
    logic [15:0]   Instr_Count;

    always #5 Clock = ~Clock;

    proc_sequencer #(.AW(AW), .TIMEOUT(7)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .Start       (Start),
        .Step        (Step),
        .Pause       (Pause),
        .Rom_Addr    (Rom_Addr),
        .Rom_Q       (Rom_Q),
        .Proc_DIN    (Proc_DIN),
        .Proc_Run    (Proc_Run),
        .Proc_Done   (Proc_Done),
        .PC          (PC),
        .Busy        (Busy),
        .Halted      (Halted),
        .Illegal     (Illegal),
        .Error       (Error),
        .Instr_Count (Instr_Count)
    );

    // Synchronous program ROM
    logic [8:0] rom [32];
    always @(posedge Clock) Rom_Q <= rom[Rom_Addr];

    // Simple processor: T0 latches IR on Run; mv/mvi finish in T1, add/sub in T3
    logic [8:0] ir = '0;
    logic [8:0] preg [8];
    logic [8:0] areg, greg;
    int         tstep = 0;
    bit         done_kill = 1'b0;

    assign Proc_Done = !done_kill &&
        ((tstep == 1 && ir[8:7] == 2'b00) || (tstep == 3 && ir[8:7] == 2'b01));

    always @(posedge Clock) begin
        if (!Resetn) begin
            tstep <= 0;
            for (int i = 0; i < 8; i++) preg[i] <= '0;
        end else begin
            case (tstep)
                0: if (Proc_Run) begin
                    ir    <= Proc_DIN;
                    tstep <= 1;
                end
                1: if (!done_kill) begin
                    if (ir[8:6] == 3'b000) preg[ir[5:3]] <= preg[ir[2:0]];
                    else if (ir[8:6] == 3'b001) preg[ir[5:3]] <= Proc_DIN;
                    else areg <= preg[ir[5:3]];
                    tstep <= (ir[8:7] == 2'b00) ? 0 : 2;
                end
                2: begin
                    greg  <= (ir[8:6] == 3'b010) ? areg + preg[ir[2:0]] : areg - preg[ir[2:0]];
                    tstep <= 3;
                end
                default: begin
                    preg[ir[5:3]] <= greg;
                    tstep         <= 0;
                end
            endcase
        end
    end

    // ISA-level model of what the sequencer should do with the program
    typedef struct packed {
        logic [4:0] pc;
        logic [8:0] word;
    } issue_t;

    issue_t     exp_q[$];
    logic [4:0] m_pc;
    int         m_cnt;
    bit         m_halted, m_illegal, m_error;
    logic [8:0] mregs [8];
    int         checks = 0;
    int         failures = 0;
    int         run_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0;
        m_cnt = 0;
        m_halted = 1'b0;
        m_illegal = 1'b0;
        m_error = 1'b0;
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        exp_q.delete();
    endtask

    task automatic model_run(input bit step, input bit pause, input bit dead);
        logic [8:0] w;
        logic [4:0] nxt;
        for (int n = 0; n < 256; n++) begin
            w = rom[m_pc];
            nxt = m_pc + 5'd1;
            if (w[8:6] == 3'b111) begin
                m_halted = 1'b1;
                return;
            end
            if (w[8]) begin
                m_illegal = 1'b1;
                m_pc = nxt;
                if (step) return;
                continue;
            end
            exp_q.push_back(issue_t'({m_pc, w}));
            if (dead) begin
                m_error = 1'b1;
                m_pc = nxt;
                return;
            end
            case (w[8:6])
                3'b000:  mregs[w[5:3]] = mregs[w[2:0]];
                3'b001:  mregs[w[5:3]] = rom[nxt];
                3'b010:  mregs[w[5:3]] = mregs[w[5:3]] + mregs[w[2:0]];
                default: mregs[w[5:3]] = mregs[w[5:3]] - mregs[w[2:0]];
            endcase
            if (m_cnt < 65535) m_cnt++;
            m_pc = (w[8:6] == 3'b001) ? m_pc + 5'd2 : nxt;
            if (step || pause) return;
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model, sampled 1 time unit after the edge
    task automatic compare_loop();
        bit         prev_run = 1'b0;
        logic [15:0] prev_cnt = '0;
        int         since = -1;
        logic [2:0] last_op = '0;
        issue_t     e;
        logic [4:0] nxt;
        forever begin
            @(posedge Clock);
            #1;
            if (!Resetn) begin
                prev_run = 1'b0;
                prev_cnt = '0;
                since = -1;
            end else begin
                nxt = PC + 5'd1;
                if (!Busy) begin
                    chk("idle_run", Proc_Run, 0);
                    chk("idle_din", Proc_DIN, 0);
                    chk("idle_addr", Rom_Addr, PC);
                end
                if (Proc_Run) begin
                    run_pulses++;
                    chk("run_back_to_back", prev_run, 0);
                    chk("issue_queued", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("issue_pc", PC, e.pc);
                        chk("issue_din", Proc_DIN, e.word);
                    end
                    chk("issue_addr", Rom_Addr, nxt);
                    last_op = Proc_DIN[8:6];
                    since = 0;
                end else if (since >= 0) begin
                    since++;
                end
                if (prev_run) chk("wait_din", Proc_DIN, rom[nxt]);
                if (Instr_Count != prev_cnt) begin
                    chk("retire_step", Instr_Count, prev_cnt + 16'd1);
                    chk("retire_latency", since, (last_op[2:1] == 2'b00) ? 2 : 4);
                end
                prev_run = Proc_Run;
                prev_cnt = Instr_Count;
            end
        end
    endtask

    task automatic pulse(input bit is_start);
        @(negedge Clock);
        if (is_start) Start = 1'b1;
        else Step = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        Step = 1'b0;
    endtask

    task automatic wait_idle(input int max, output int busy_cycles);
        busy_cycles = 0;
        for (int n = 0; n < max; n++) begin
            if (!Busy) return;
            busy_cycles++;
            @(negedge Clock);
        end
        chk("idle_timeout", Busy, 0);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        model_reset();
    endtask

    task automatic run_start(input bit pause, input bit dead, output int bc);
        m_pc = '0;
        m_halted = 1'b0;
        model_run(1'b0, pause, dead);
        pulse(1'b1);
        wait_idle(300, bc);
    endtask

    task automatic check_final(input string tag);
        chk({tag, "_pc"}, PC, m_pc);
        chk({tag, "_count"}, Instr_Count, m_cnt);
        chk({tag, "_halted"}, Halted, m_halted);
        chk({tag, "_illegal"}, Illegal, m_illegal);
        chk({tag, "_error"}, Error, m_error);
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_busy"}, Busy, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_r%0d", tag, i), preg[i], mregs[i]);
    endtask

    task automatic load_prog2();
        for (int i = 0; i < 32; i++) rom[i] = HALT_W;
        rom[0] = 9'b001000000;
        rom[1] = 9'd3;
        rom[2] = 9'b001001000;
        rom[3] = 9'd4;
        rom[4] = 9'b010000001;
        rom[5] = HALT_W;
    endtask

    initial begin
        int bc;
        int rp;
        bit found;
        logic [4:0] step_pc [3];
        step_pc[0] = 5'd2;
        step_pc[1] = 5'd4;
        step_pc[2] = 5'd5;
        for (int i = 0; i < 32; i++) rom[i] = HALT_W;
        fork
            compare_loop();
        join_none

        // Reset state
        @(negedge Clock);
        chk("rst_pc", PC, 0);
        chk("rst_count", Instr_Count, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_flags", {Halted, Illegal, Error}, 0);
        chk("rst_run", Proc_Run, 0);
        chk("rst_din", Proc_DIN, 0);
        chk("rst_addr", Rom_Addr, 0);
        @(negedge Clock);
        Resetn = 1'b1;
        model_reset();

        // mvi R0,#5 then HALT
        rom[0] = 9'b001000000;
        rom[1] = 9'd5;
        rom[2] = HALT_W;
        rp = run_pulses;
        run_start(1'b0, 1'b0, bc);
        check_final("t1");
        chk("t1_r0_lit", preg[0], 9'd5);
        chk("t1_pc_lit", PC, 2);
        chk("t1_halted_lit", Halted, 1);
        chk("t1_count_lit", Instr_Count, 1);
        chk("t1_runs_lit", run_pulses - rp, 1);

        // mvi, mvi, add, HALT
        do_reset();
        load_prog2();
        run_start(1'b0, 1'b0, bc);
        check_final("t2");
        chk("t2_r0_lit", preg[0], 9'd7);
        chk("t2_count_lit", Instr_Count, 3);
        chk("t2_pc_lit", PC, 5);

        // Illegal word skipped, then HALT
        do_reset();
        for (int i = 0; i < 32; i++) rom[i] = HALT_W;
        rom[0] = 9'b101000000;
        rp = run_pulses;
        run_start(1'b0, 1'b0, bc);
        check_final("t3");
        chk("t3_illegal_lit", Illegal, 1);
        chk("t3_pc_lit", PC, 1);
        chk("t3_halted_lit", Halted, 1);
        chk("t3_runs_lit", run_pulses - rp, 0);

        // Single-step through the three-instruction program
        do_reset();
        load_prog2();
        for (int i = 0; i < 3; i++) begin
            model_run(1'b1, 1'b0, 1'b0);
            pulse(1'b0);
            wait_idle(50, bc);
            check_final($sformatf("t4_step%0d", i));
            chk($sformatf("t4_pc_lit%0d", i), PC, step_pc[i]);
            chk($sformatf("t4_count_lit%0d", i), Instr_Count, i + 1);
        end

        // Done never arrives
        do_reset();
        for (int i = 0; i < 32; i++) rom[i] = HALT_W;
        rom[0] = 9'b001000000;
        rom[1] = 9'd5;
        done_kill = 1'b1;
        run_start(1'b0, 1'b1, bc);
        check_final("t5");
        chk("t5_error_lit", Error, 1);
        chk("t5_pc_lit", PC, 1);
        chk("t5_busy_cycles_lit", bc, 9);
        chk("t5_count_lit", Instr_Count, 0);
        done_kill = 1'b0;

        // Reset in the middle of an add, then a clean restart
        do_reset();
        load_prog2();
        m_pc = '0;
        model_run(1'b0, 1'b0, 1'b0);
        pulse(1'b1);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            if (Proc_Run && Proc_DIN[8:6] == 3'b010) found = 1'b1;
            else @(negedge Clock);
        end
        chk("t6_add_issued", found, 1);
        @(negedge Clock);
        Resetn = 1'b0;
        @(negedge Clock);
        chk("t6_rst_busy", Busy, 0);
        chk("t6_rst_pc", PC, 0);
        chk("t6_rst_count", Instr_Count, 0);
        chk("t6_rst_run", Proc_Run, 0);
        Resetn = 1'b1;
        model_reset();
        run_start(1'b0, 1'b0, bc);
        check_final("t6");
        chk("t6_r0_lit", preg[0], 9'd7);
        chk("t6_count_lit", Instr_Count, 3);

        // Pause held: illegals skipped, mvi at last address wraps for its immediate
        do_reset();
        rom[0] = 9'b110000111;
        for (int i = 1; i < 31; i++) rom[i] = 9'b100000000;
        rom[31] = 9'b001010000;
        Pause = 1'b1;
        run_start(1'b1, 1'b0, bc);
        Pause = 1'b0;
        check_final("t7");
        chk("t7_pc_lit", PC, 1);
        chk("t7_r2_lit", preg[2], 9'h187);
        chk("t7_count_lit", Instr_Count, 1);
        chk("t7_illegal_lit", Illegal, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
